idct4_stream: RTL

Streaming, parametrised 4x4 inverse transform engine that succeeds the fixed four-stage time-multiplexed IDCT. It accepts one coefficient column per beat over a valid/ready handshake and performs the vertical pass with a configurable round/shift/clip. Intermediates go to a ping-pong transpose buffer. The horizontal pass emits one residual row per beat. Per-block mode selects the HEVC 4-point inverse DCT or the inverse DST-VII used for 4x4 intra luma. It sits between the coefficient dequantiser and the reconstruction adder.

---
 rtl/idct4_stream.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/idct4_stream.sv
// Streaming 4x4 inverse DCT / DST-VII: column-wise vertical pass into a
// ping-pong transpose buffer, row-wise horizontal pass into an output register.

module idct4_1d #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 16,
  parameter int SHIFT = 7
) (
  input  logic                    i_mode,
  input  logic signed [W_IN-1:0]  i_c0,
  input  logic signed [W_IN-1:0]  i_c1,
  input  logic signed [W_IN-1:0]  i_c2,
  input  logic signed [W_IN-1:0]  i_c3,
  output logic signed [W_OUT-1:0] o_y0,
  output logic signed [W_OUT-1:0] o_y1,
  output logic signed [W_OUT-1:0] o_y2,
  output logic signed [W_OUT-1:0] o_y3
);
  localparam int ACC = W_IN + 9;
  localparam logic signed [ACC-1:0] K29 = ACC'(29);
  localparam logic signed [ACC-1:0] K36 = ACC'(36);
  localparam logic signed [ACC-1:0] K55 = ACC'(55);
  localparam logic signed [ACC-1:0] K64 = ACC'(64);
  localparam logic signed [ACC-1:0] K74 = ACC'(74);
  localparam logic signed [ACC-1:0] K83 = ACC'(83);
  localparam logic signed [ACC-1:0] K84 = ACC'(84);
  localparam logic signed [ACC-1:0] RND  = ACC'(1) << (SHIFT - 1);
  localparam logic signed [ACC-1:0] MAXV = {{(ACC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [ACC-1:0] MINV = ~MAXV;

  logic signed [ACC-1:0] w_c0, w_c1, w_c2, w_c3;
  logic signed [ACC-1:0] w_e0, w_e1, w_o0, w_o1;
  logic signed [ACC-1:0] w_r [4];

  assign w_c0 = ACC'(i_c0);
  assign w_c1 = ACC'(i_c1);
  assign w_c2 = ACC'(i_c2);
  assign w_c3 = ACC'(i_c3);

  always_comb begin
    w_e0 = K64 * (w_c0 + w_c2);
    w_e1 = K64 * (w_c0 - w_c2);
    w_o0 = K83 * w_c1 + K36 * w_c3;
    w_o1 = K36 * w_c1 - K83 * w_c3;
    if (i_mode) begin
      w_r[0] = K29 * w_c0 + K74 * w_c1 + K84 * w_c2 + K55 * w_c3;
      w_r[1] = K55 * w_c0 + K74 * w_c1 - K29 * w_c2 - K84 * w_c3;
      w_r[2] = K74 * w_c0 - K74 * w_c2 + K74 * w_c3;
      w_r[3] = K84 * w_c0 - K74 * w_c1 + K55 * w_c2 - K29 * w_c3;
    end else begin
      w_r[0] = w_e0 + w_o0;
      w_r[1] = w_e1 + w_o1;
      w_r[2] = w_e1 - w_o1;
      w_r[3] = w_e0 - w_o0;
    end
  end

  // Round, floor-shift, then clamp into the narrower target width.
  function automatic logic signed [W_OUT-1:0] norm(input logic signed [ACC-1:0] v);
    logic signed [ACC-1:0] s;
    s = (v + RND) >>> SHIFT;
    if (s > MAXV)      return MAXV[W_OUT-1:0];
    else if (s < MINV) return MINV[W_OUT-1:0];
    else               return s[W_OUT-1:0];
  endfunction

  assign o_y0 = norm(w_r[0]);
  assign o_y1 = norm(w_r[1]);
  assign o_y2 = norm(w_r[2]);
  assign o_y3 = norm(w_r[3]);
endmodule

module idct4_stream #(
  parameter int IN_W   = 16,
  parameter int MID_W  = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT1 = 7,
  parameter int SHIFT2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [IN_W-1:0]  in_d0,
  input  logic signed [IN_W-1:0]  in_d1,
  input  logic signed [IN_W-1:0]  in_d2,
  input  logic signed [IN_W-1:0]  in_d3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_row,
  output logic                    out_last,
  output logic                    out_mode,
  output logic signed [OUT_W-1:0] out_d0,
  output logic signed [OUT_W-1:0] out_d1,
  output logic signed [OUT_W-1:0] out_d2,
  output logic signed [OUT_W-1:0] out_d3
);
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bank_st_t;

  bank_st_t r_st [2];
  bank_st_t w_st_nxt [2];
  logic       r_wptr, r_rptr;
  logic [1:0] r_beat, r_row;
  logic [1:0] r_bmode;
  logic signed [MID_W-1:0] r_bank [2][4][4];

  logic w_in_ready, w_in_fire, w_load, w_mode1;
  logic signed [MID_W-1:0] w_e0, w_e1, w_e2, w_e3;
  logic signed [OUT_W-1:0] w_y0, w_y1, w_y2, w_y3;

  logic                    r_ovalid, r_olast, r_omode;
  logic [1:0]              r_orow;
  logic signed [OUT_W-1:0] r_od0, r_od1, r_od2, r_od3;

  // Mode is only taken from the port on beat 0; later beats reuse the stored bit.
  assign w_mode1 = (r_beat == 2'd0) ? in_mode : r_bmode[r_wptr];

  idct4_1d #(.W_IN(IN_W), .W_OUT(MID_W), .SHIFT(SHIFT1)) u_pass1 (
    .i_mode(w_mode1), .i_c0(in_d0), .i_c1(in_d1), .i_c2(in_d2), .i_c3(in_d3),
    .o_y0(w_e0), .o_y1(w_e1), .o_y2(w_e2), .o_y3(w_e3)
  );

  idct4_1d #(.W_IN(MID_W), .W_OUT(OUT_W), .SHIFT(SHIFT2)) u_pass2 (
    .i_mode(r_bmode[r_rptr]),
    .i_c0(r_bank[r_rptr][r_row][0]), .i_c1(r_bank[r_rptr][r_row][1]),
    .i_c2(r_bank[r_rptr][r_row][2]), .i_c3(r_bank[r_rptr][r_row][3]),
    .o_y0(w_y0), .o_y1(w_y1), .o_y2(w_y2), .o_y3(w_y3)
  );

  // Bank-control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st[0] <= B_FREE;
      r_st[1] <= B_FREE;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_beat  <= 2'd0;
      r_row   <= 2'd0;
      r_bmode <= 2'b00;
    end else begin
      r_st <= w_st_nxt;
      if (w_in_fire) begin
        r_beat <= r_beat + 2'd1;
        if (r_beat == 2'd0) r_bmode[r_wptr] <= in_mode;
        if (r_beat == 2'd3) r_wptr <= ~r_wptr;
      end
      if (w_load) begin
        r_row <= r_row + 2'd1;
        if (r_row == 2'd3) r_rptr <= ~r_rptr;
      end
    end
  end

  // Writer and reader always address different banks, so both updates can coexist.
  always_comb begin
    w_st_nxt = r_st;
    if (w_in_fire) w_st_nxt[r_wptr] = (r_beat == 2'd3) ? B_FULL : B_FILLING;
    if (w_load && r_row == 2'd3) w_st_nxt[r_rptr] = B_FREE;
  end

  always_comb begin
    w_in_ready = !reset && (r_st[r_wptr] != B_FULL);
    w_in_fire  = in_valid && w_in_ready;
    w_load     = (r_st[r_rptr] == B_FULL) && (!r_ovalid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_bank[r_wptr][0][r_beat] <= w_e0;
      r_bank[r_wptr][1][r_beat] <= w_e1;
      r_bank[r_wptr][2][r_beat] <= w_e2;
      r_bank[r_wptr][3][r_beat] <= w_e3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_omode  <= 1'b0;
      r_orow   <= 2'd0;
      r_od0    <= '0;
      r_od1    <= '0;
      r_od2    <= '0;
      r_od3    <= '0;
    end else if (w_load) begin
      r_ovalid <= 1'b1;
      r_olast  <= (r_row == 2'd3);
      r_omode  <= r_bmode[r_rptr];
      r_orow   <= r_row;
      r_od0    <= w_y0;
      r_od1    <= w_y1;
      r_od2    <= w_y2;
      r_od3    <= w_y3;
    end else if (out_ready) begin
      r_ovalid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_ovalid;
  assign out_row   = r_orow;
  assign out_last  = r_olast;
  assign out_mode  = r_omode;
  assign out_d0    = r_od0;
  assign out_d1    = r_od1;
  assign out_d2    = r_od2;
  assign out_d3    = r_od3;
endmodule
